row_fetch_responder: RTL and testbench
======================================

# row_fetch_responder

Consumer end of the row-address stream: accepts `row_addr`/`valid` requests, one per cycle, issues synchronous reads to a row memory, and buffers the returned words in a small FIFO. It then delivers them downstream over a ready/valid handshake, tagged with their row index. The block counts delivered rows, flags frame completion after `NUM_ROWS`, and reports dropped or illegal requests through sticky error flags. The request side has no backpressure, so the block never stalls it.

## Interface
- `ADDR_W`, 10, row address width
- `DATA_W`, 32, memory word width
- `NUM_ROWS`, 720, rows per frame; legal addresses are 0..`NUM_ROWS`-1
- `FIFO_DEPTH`, 4, output buffer entries (power of 2, ≥4)

- `clk` in 1: the single clock, rising edge
- `reset` in 1: synchronous, active-high
- `row_addr` in `ADDR_W`: requested row
- `valid` in 1: `row_addr` is a request this cycle
- `mem_en` out 1: memory read enable
- `mem_addr` out `ADDR_W`: memory read address
- `mem_rdata` in `DATA_W`: read data, valid exactly 1 cycle after `mem_en`
- `out_data` out `DATA_W`: head-of-FIFO word
- `out_row` out `ADDR_W`: row index of `out_data`
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: downstream accepts
- `overflow` out 1: sticky; a request was dropped for lack of credit
- `addr_err` out 1: sticky; a request had `row_addr >= NUM_ROWS`
- `frame_done` out 1: sticky; `NUM_ROWS` rows delivered

## Operation
- **FSM states:** IDLE, STREAM, DONE.
  - IDLE → STREAM on the first accepted request.
  - STREAM → DONE on the cycle `rows_out` reaches `NUM_ROWS`.
  - DONE holds until `reset`.
- **Credit:** `credit_used` = FIFO occupancy + requests in flight (stage-1 and stage-2 valid bits).
  - A request is accepted when `valid`, the state is not DONE, `row_addr < NUM_ROWS`, and `credit_used < FIFO_DEPTH`.
  - A pop in the same cycle does not free credit; credit is freed only from the next cycle.
- **Dropped requests:**
  - `valid` with `row_addr >= NUM_ROWS`: dropped, `addr_err` set, no `mem_en`. Range is checked before credit.
  - `valid`, legal address, no credit: dropped, `overflow` set.
  - `valid` in DONE: ignored, no flag set.
- **Pipeline:**
  - Stage 1 registers `mem_en`=1, `mem_addr`=`row_addr`.
  - Stage 2 carries the row tag alongside the memory access.
  - `mem_rdata` and its tag are written into the FIFO at the end of the stage-2 cycle.
- **FIFO:** in order, no reordering.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - A push never occurs when full; the credit scheme guarantees this, and an assertion checks it.
- **Counter:** `rows_out` is `ADDR_W`+1 bits and increments on `out_valid && out_ready`. It saturates at `NUM_ROWS`.
- **Reset values:** all outputs 0 (`mem_en`, `mem_addr`, `out_data`, `out_row`, `out_valid`, `overflow`, `addr_err`, `frame_done`). FIFO pointers, counters and in-flight bits are also cleared, and the FSM returns to IDLE. Reset applies mid-frame with no drain.

## Timing
- `valid` in cycle N → `mem_en`/`mem_addr` in N+1 → `mem_rdata` in N+2 → `out_valid` in N+3 if the FIFO was empty. Minimum latency is 3 cycles.
- With `out_ready` held high, throughput is 1 row/cycle and `credit_used` stays ≤3, so there is never an overflow.
- `frame_done` rises in the cycle after the `NUM_ROWS`-th pop.
- `overflow` and `addr_err` rise in the cycle after the offending request.
- `out_data`/`out_row` remain stable while `out_valid && !out_ready`.
- With `reset` high in cycle N, all outputs are at reset values in N+1. Requests present in cycle N are discarded.

## Structure
- **Shared package:** `NUM_ROWS`, `ADDR_W`, `DATA_W`, and a state enum typedef (IDLE/STREAM/DONE), shared with the address generator.
- **Sub-module `row_fifo`:** synchronous FIFO with width `DATA_W+ADDR_W`, depth `FIFO_DEPTH`, `count` output, and the same `clk`/`reset`.
- The top level holds the FSM, credit logic, the two-stage request pipeline and the counter.

## Test plan
- **Reset:** assert `reset` 2 cycles with `valid`=1 → all outputs 0, no `mem_en`.
- **Full frame:** `valid`=1 with `row_addr` 0..719 on consecutive cycles, `out_ready`=1, memory returns `{22'h0, addr}` → `out_row` 0..719 in order. First `out_valid` 3 cycles after the first `valid`. `frame_done`=1 after 720 pops; `overflow`=`addr_err`=0.
- **Backpressure:** `out_ready`=0 while streaming rows 0..9 → only rows 0..3 accepted, `overflow`=1 from the cycle after the row-4 request. Release `out_ready` → rows 0,1,2,3 delivered, then `out_valid`=0.
- **Illegal address:** `row_addr`=720 with `valid`=1 → no `mem_en`, `addr_err`=1 next cycle. A following request for row 5 is delivered normally.
- **Full boundary:** with the FIFO full (4 entries), pop one while a request arrives → request dropped (`overflow`=1) and occupancy falls to 3. A request one cycle later is accepted.
- **Mid-frame reset:** `reset` after 100 rows delivered → next cycle `out_valid`=0, `rows_out`=0, flags 0. Restart from row 0 completes the frame with `frame_done` after 720 pops.

Source files
------------

// File: rtl/row_fetch_responder_pkg.sv
// Shared constants and state type for the row-address stream producer and consumer.
package row_fetch_responder_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int NUM_ROWS   = 720;
  localparam int FIFO_DEPTH = 4;

  // Row limits expressed at counter width so comparisons stay width-exact.
  localparam logic [ADDR_W:0] ROWS_LIMIT = (ADDR_W + 1)'(NUM_ROWS);
  localparam logic [ADDR_W:0] LAST_ROW   = (ADDR_W + 1)'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/row_fetch_responder_if.sv
// Request, memory and output-stream signals of the row fetch responder.
interface row_fetch_responder_if;
  import row_fetch_responder_pkg::*;

  logic [ADDR_W-1:0] row_addr;
  logic              valid;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_row;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              addr_err;
  logic              frame_done;

  // Environment side: request source, row memory and downstream sink.
  modport master (
    output row_addr, valid, mem_rdata, out_ready,
    input  mem_en, mem_addr, out_data, out_row, out_valid,
           overflow, addr_err, frame_done
  );

  // Responder side.
  modport slave (
    input  row_addr, valid, mem_rdata, out_ready,
    output mem_en, mem_addr, out_data, out_row, out_valid,
           overflow, addr_err, frame_done
  );

endinterface

// File: rtl/row_fetch_responder_row_fifo.sv
// Small in-order synchronous FIFO holding {word, row tag} entries.
module row_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;

  // DEPTH is a power of two, so the count MSB alone marks a full buffer.
  assign full  = count[PW];
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Upstream credit accounting must never let a push land on a full buffer.
  no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/row_fetch_responder.sv
// Consumer end of the row-address stream: credit-gated memory reads, output FIFO,
// delivered-row counter and sticky status flags.
module row_fetch_responder
  import row_fetch_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  row_fetch_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  state_t            state_q;
  state_t            state_d;
  logic              frame_done;

  logic              vld_p1;
  logic [ADDR_W-1:0] row_p1;
  logic              vld_p2;
  logic [ADDR_W-1:0] row_p2;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  logic [CRD_W-1:0]  credit_used;
  logic              in_range;
  logic              req_live;
  logic              accept;
  logic              pop;

  logic [ADDR_W:0]   rows_out;
  logic              overflow_q;
  logic              addr_err_q;

  // Delivered-row count holds once a full frame has gone out.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v >= ROWS_LIMIT) ? v : v + 1'b1;
  endfunction

  // Credit covers buffered entries plus both in-flight stages; a pop this
  // cycle is only reflected once fifo_count updates next cycle.
  assign credit_used = CRD_W'(fifo_count) + CRD_W'(vld_p1) + CRD_W'(vld_p2);
  assign in_range    = ({1'b0, bus.row_addr} < ROWS_LIMIT);
  assign req_live    = bus.valid && (state_q != DONE);
  assign accept      = req_live && in_range && (credit_used < CRD_W'(FIFO_DEPTH));
  assign pop         = !fifo_empty && bus.out_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; DONE is entered on the pop that completes the frame.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (pop && (rows_out == LAST_ROW)) state_d = DONE;
      DONE:    frame_done = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage 1: issue the memory read ----
  // mem_addr is a visible output, so the address register is cleared too.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) row_p1 <= bus.row_addr;
    end
  end

  // ---- stage 2: row tag travels with the outstanding memory access ----
  always_ff @(posedge clk) begin
    if (reset) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  // Stage-2 tag is pure data.
  always_ff @(posedge clk) begin
    row_p2 <= row_p1;
  end

  // ---- buffer: returned word and tag pushed at the end of stage 2 ----
  row_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p2),
    .wdata ({bus.mem_rdata, row_p2}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Delivered-row counter.
  always_ff @(posedge clk) begin
    if (reset)    rows_out <= '0;
    else if (pop) rows_out <= sat_inc(rows_out);
  end

  // Sticky error flags; range is checked before credit, and DONE ignores requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (req_live && in_range && !accept);
      addr_err_q <= addr_err_q | (req_live && !in_range);
    end
  end

  assign bus.mem_en     = vld_p1;
  assign bus.mem_addr   = row_p1;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_empty ? '0 : fifo_head[ENT_W-1:ADDR_W];
  assign bus.out_row    = fifo_empty ? '0 : fifo_head[ADDR_W-1:0];
  assign bus.overflow   = overflow_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_row_fetch_responder.sv
// Randomised bench for row_fetch_responder with a queue-based reference model.
module tb_row_fetch_responder;
  import row_fetch_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  row_fetch_responder_if bus();

  row_fetch_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Row memory: one-cycle read latency, junk on the bus when not enabled.
  logic [DATA_W-1:0] mem_tbl [1 << ADDR_W];
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_en ? mem_tbl[bus.mem_addr] : DATA_W'($urandom);
  end

  // Reference model: every accepted, not yet delivered request with its accept cycle.
  typedef struct { int row; int acc; } req_t;
  req_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  bit   acc_prev = 1'b0;
  logic [ADDR_W-1:0] last_row = '0;
  int   rows_m = 0;
  bit   done_m = 1'b0, ovf_m = 1'b0, aerr_m = 1'b0;
  bit   exp_ov, new_acc;

  string       lit_name;
  logic [63:0] lit_act, lit_exp;
  bit          lit_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model mid-cycle, then advance the model by one edge.
  always @(negedge clk) begin
    exp_ov = (q.size() > 0) && (q[0].acc + 3 <= cyc);
    if (armed) begin
      chk("mem_en", 64'(bus.mem_en), 64'(acc_prev));
      if (acc_prev) chk("mem_addr", 64'(bus.mem_addr), 64'(last_row));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (exp_ov) begin
        chk("out_row", 64'(bus.out_row), 64'(q[0].row));
        chk("out_data", 64'(bus.out_data), 64'(mem_tbl[q[0].row]));
      end
      chk("overflow", 64'(bus.overflow), 64'(ovf_m));
      chk("addr_err", 64'(bus.addr_err), 64'(aerr_m));
      chk("frame_done", 64'(bus.frame_done), 64'(done_m));
      if (lit_pend) chk(lit_name, lit_act, lit_exp);
    end
    if (reset) begin
      q.delete();
      acc_prev = 1'b0;
      rows_m   = 0;
      done_m   = 1'b0;
      ovf_m    = 1'b0;
      aerr_m   = 1'b0;
      armed    = 1'b1;
    end else begin
      new_acc = 1'b0;
      if (bus.valid && !done_m) begin
        if (int'(bus.row_addr) >= NUM_ROWS) aerr_m = 1'b1;
        else if (q.size() < FIFO_DEPTH) begin
          q.push_back('{row: int'(bus.row_addr), acc: cyc});
          new_acc  = 1'b1;
          last_row = bus.row_addr;
        end else ovf_m = 1'b1;
      end
      if (exp_ov && bus.out_ready) begin
        void'(q.pop_front());
        if (rows_m < NUM_ROWS) rows_m++;
        if (rows_m == NUM_ROWS) done_m = 1'b1;
      end
      acc_prev = new_acc;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation, evaluated by the compare process this cycle.
  task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
    bus.valid = 1'b0;
    lit_name  = nm;
    lit_act   = a;
    lit_exp   = e;
    lit_pend  = 1'b1;
    @(negedge clk);
    #1 lit_pend = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.valid = 1'($urandom);
    step();
    reset     = 1'b0;
    bus.valid = 1'b0;
  endtask

  task automatic run_frame(output int first_ov, output int pops);
    first_ov      = -1;
    pops          = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_ROWS; i++) begin
      bus.valid    = 1'b1;
      bus.row_addr = ADDR_W'(i);
      if (bus.out_valid && first_ov < 0) first_ov = i;
      if (bus.out_valid) pops++;
      step();
    end
    bus.valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) pops++;
      step();
    end
  endtask

  int first_ov, pops, lim;
  logic a0, a1, b0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem_tbl[i] = DATA_W'($urandom);
    reset         = 1'b1;
    bus.valid     = 1'b1;
    bus.row_addr  = ADDR_W'($urandom_range(0, NUM_ROWS - 1));
    bus.out_ready = 1'b0;

    // Reset held two cycles with requests present.
    step();
    step();
    reset     = 1'b0;
    bus.valid = 1'b0;
    lit("reset_outputs", 64'({bus.mem_en, bus.out_valid, bus.overflow, bus.addr_err,
        bus.frame_done, bus.mem_addr, bus.out_data, bus.out_row}), 64'd0);

    // Full frame at full rate.
    run_frame(first_ov, pops);
    lit("first_latency", 64'(first_ov), 64'd3);
    lit("frame_pops", 64'(pops), 64'd720);
    lit("frame_done", 64'(bus.frame_done), 64'd1);
    lit("frame_flags", 64'({bus.overflow, bus.addr_err}), 64'd0);
    bus.valid = 1'b1; bus.row_addr = ADDR_W'(1000); step();
    bus.valid = 1'b1; bus.row_addr = ADDR_W'(3);    step();
    lit("done_ignores", 64'({bus.addr_err, bus.overflow, bus.mem_en}), 64'd0);

    // Backpressure: only four requests fit.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.valid = 1'b1; bus.row_addr = ADDR_W'(i);
      if (i == 4) a0 = bus.overflow;
      if (i == 5) a1 = bus.overflow;
      step();
    end
    bus.valid = 1'b0;
    step(); step();
    lit("bp_ovf_before", 64'(a0), 64'd0);
    lit("bp_ovf_after", 64'(a1), 64'd1);
    bus.out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) pops++;
      step();
    end
    lit("bp_pops", 64'(pops), 64'd4);

    // Illegal address followed by a legal one.
    do_reset();
    bus.out_ready = 1'b1;
    bus.valid = 1'b1; bus.row_addr = ADDR_W'(NUM_ROWS); step();
    bus.valid = 1'b1; bus.row_addr = ADDR_W'(5);
    a0 = bus.addr_err; b0 = bus.mem_en;
    step();
    bus.valid = 1'b0;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) pops++;
      step();
    end
    lit("illegal_flag", 64'({a0, b0}), 64'b10);
    lit("illegal_pops", 64'(pops), 64'd1);

    // Full boundary: pop and request in the same cycle.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid = 1'b1; bus.row_addr = ADDR_W'($urandom_range(0, NUM_ROWS - 1));
      step();
    end
    bus.valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b1;
    bus.valid = 1'b1; bus.row_addr = ADDR_W'($urandom_range(0, NUM_ROWS - 1));
    a0 = bus.overflow;
    step();
    bus.out_ready = 1'b0;
    bus.valid = 1'b1; bus.row_addr = ADDR_W'($urandom_range(0, NUM_ROWS - 1));
    a1 = bus.overflow;
    step();
    bus.valid = 1'b0;
    lit("full_ovf", 64'({a0, a1}), 64'b01);
    bus.out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) pops++;
      step();
    end
    lit("full_pops", 64'(pops), 64'd4);

    // Mid-frame reset after 100 deliveries, then a complete frame.
    do_reset();
    bus.out_ready = 1'b1;
    pops = 0;
    lim  = 0;
    while (pops < 100 && lim < 200) begin
      bus.valid = 1'b1; bus.row_addr = ADDR_W'(lim);
      if (bus.out_valid) pops++;
      step();
      lim++;
    end
    lit("mid_pops", 64'(pops), 64'd100);
    reset = 1'b1; bus.valid = 1'b1; step();
    reset = 1'b0; bus.valid = 1'b0;
    lit("mid_reset_outs", 64'({bus.out_valid, bus.overflow, bus.addr_err,
        bus.frame_done, bus.mem_en}), 64'd0);
    run_frame(first_ov, pops);
    lit("restart_pops", 64'(pops), 64'd720);
    lit("restart_done", 64'(bus.frame_done), 64'd1);

    // Random traffic with illegal rows, backpressure and sporadic resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 499) == 0);
      bus.valid     = ($urandom_range(0, 3) != 0);
      bus.row_addr  = ($urandom_range(0, 15) == 0) ?
                      ADDR_W'($urandom_range(NUM_ROWS, (1 << ADDR_W) - 1)) :
                      ADDR_W'($urandom_range(0, NUM_ROWS - 1));
      bus.out_ready = (i % 600 < 300) ? ($urandom_range(0, 2) != 0)
                                      : ($urandom_range(0, 3) == 0);
      step();
    end
    reset     = 1'b0;
    bus.valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
